// File: rtl/jtopl_acc_mix.sv
// Frame accumulator and output mixer for the OPL operator pipeline.
// Operator results are summed per frame into left/right accumulators. At
// the first slot of the next frame each sum is saturated to the output
// width and published, and a one-cycle sample strobe follows. A slot
// counter checks frame length and keeps a sticky error flag.
module jtopl_acc_mix #(
  parameter int OPW    = 13,
  parameter int OUTW   = 16,
  parameter int ACCW   = 18,
  parameter int SLOTS  = 18,
  parameter int STEREO = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cenop,
  input  logic signed [OPW-1:0]  op_result,
  input  logic                   zero,
  input  logic                   op,
  input  logic                   con,
  input  logic                   rhy_IV,
  input  logic                   pan_l,
  input  logic                   pan_r,
  output logic signed [OUTW-1:0] snd_l,
  output logic signed [OUTW-1:0] snd_r,
  output logic                   sample,
  output logic                   clip_l,
  output logic                   clip_r,
  output logic                   frame_err
);

  localparam int CNTW = $clog2(SLOTS + 1);
  localparam logic [CNTW-1:0] LAST_SLOT = CNTW'(SLOTS - 1);
  localparam logic [CNTW-1:0] FULL_SLOT = CNTW'(SLOTS);

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] OUT_MAX = {{(ACCW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACCW-1:0] acc_l;
  logic signed [ACCW-1:0] acc_r;
  logic [CNTW-1:0]        slot_cnt;
  logic                   first_frame;

  logic signed [ACCW-1:0] op_ext;
  logic signed [ACCW-1:0] contrib;
  logic signed [ACCW-1:0] contrib_l;
  logic signed [ACCW-1:0] contrib_r;
  logic                   pan_r_eff;
  logic signed [ACCW-1:0] acc_l_nxt;
  logic signed [ACCW-1:0] acc_r_nxt;

  // Accumulator add that clamps at the accumulator limits instead of wrapping,
  // so a frame that overshoots still publishes a full-scale sample.
  function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                     input logic signed [ACCW-1:0] b);
    logic signed [ACCW:0] s;
    s = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (s[ACCW] != s[ACCW-1]) begin
      return s[ACCW] ? ACC_MIN : ACC_MAX;
    end
    return s[ACCW-1:0];
  endfunction

  // Clamp an accumulator value into the output range.
  function automatic logic signed [OUTW-1:0] sat_out(input logic signed [ACCW-1:0] a);
    if (a > OUT_MAX) begin
      return {1'b0, {(OUTW-1){1'b1}}};
    end
    if (a < OUT_MIN) begin
      return {1'b1, {(OUTW-1){1'b0}}};
    end
    return OUTW'(a);
  endfunction

  function automatic logic clipped(input logic signed [ACCW-1:0] a);
    return (a > OUT_MAX) || (a < OUT_MIN);
  endfunction

  // Per-slot gated contribution and next accumulator values.
  always_comb begin
    op_ext    = {{(ACCW-OPW){op_result[OPW-1]}}, op_result};
    contrib   = '0;
    if (cenop && (op || con)) begin
      contrib = rhy_IV ? (op_ext <<< 1) : op_ext;
    end
    pan_r_eff = (STEREO != 0) ? pan_r : pan_l;
    contrib_l = pan_l     ? contrib : '0;
    contrib_r = pan_r_eff ? contrib : '0;
    acc_l_nxt = zero ? contrib_l : sat_add(acc_l, contrib_l);
    acc_r_nxt = zero ? contrib_r : sat_add(acc_r, contrib_r);
  end

  // Frame state: accumulate on cenop, publish and restart on zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_l       <= '0;
      acc_r       <= '0;
      snd_l       <= '0;
      snd_r       <= '0;
      sample      <= 1'b0;
      clip_l      <= 1'b0;
      clip_r      <= 1'b0;
      frame_err   <= 1'b0;
      slot_cnt    <= '0;
      first_frame <= 1'b1;
    end else begin
      sample <= cenop && zero;
      if (cenop) begin
        acc_l <= acc_l_nxt;
        acc_r <= acc_r_nxt;
        if (zero) begin
          // The first zero after reset publishes silence whatever arrived before it.
          if (first_frame) begin
            snd_l  <= '0;
            snd_r  <= '0;
            clip_l <= 1'b0;
            clip_r <= 1'b0;
          end else begin
            snd_l  <= sat_out(acc_l);
            snd_r  <= sat_out(acc_r);
            clip_l <= clipped(acc_l);
            clip_r <= clipped(acc_r);
            if (slot_cnt != LAST_SLOT) begin
              frame_err <= 1'b1;
            end
          end
          slot_cnt    <= '0;
          first_frame <= 1'b0;
        end else begin
          if (slot_cnt != FULL_SLOT) begin
            slot_cnt <= slot_cnt + CNTW'(1);
          end
          if (slot_cnt >= LAST_SLOT) begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtopl_acc_mix.sv
// Bench for jtopl_acc_mix: a mono instance (STEREO=0) and a stereo instance
// (STEREO=1) share stimulus; published samples are scored against queues
// filled by a reference frame model as slots are driven.
module tb_jtopl_acc_mix;

  localparam int OUTW = 16;
  localparam int W    = 2 + 2 * OUTW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cenop = 1'b0;
  logic signed [12:0] op_result = '0;
  logic zero = 1'b0, op = 1'b0, con = 1'b0, rhy_IV = 1'b0, pan_l = 1'b0, pan_r = 1'b0;

  logic signed [OUTW-1:0] snd_l0, snd_r0, snd_l1, snd_r1;
  logic sample0, clip_l0, clip_r0, frame_err0;
  logic sample1, clip_l1, clip_r1, frame_err1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] e0, e1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ml = 0, mr = 0;
  bit first_f = 1'b1;
  bit gap_en  = 1'b1;

  jtopl_acc_mix dut (
    .clk(clk), .rst(rst), .cenop(cenop), .op_result(op_result), .zero(zero),
    .op(op), .con(con), .rhy_IV(rhy_IV), .pan_l(pan_l), .pan_r(pan_r),
    .snd_l(snd_l0), .snd_r(snd_r0), .sample(sample0), .clip_l(clip_l0),
    .clip_r(clip_r0), .frame_err(frame_err0)
  );

  jtopl_acc_mix #(.STEREO(1)) dut_st (
    .clk(clk), .rst(rst), .cenop(cenop), .op_result(op_result), .zero(zero),
    .op(op), .con(con), .rhy_IV(rhy_IV), .pan_l(pan_l), .pan_r(pan_r),
    .snd_l(snd_l1), .snd_r(snd_r1), .sample(sample1), .clip_l(clip_l1),
    .clip_r(clip_r1), .frame_err(frame_err1)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [OUTW-1:0] sat16(input int x);
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return x[OUTW-1:0];
  endfunction

  function automatic logic clipped(input int x);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic logic [W-1:0] pack(input int l, input int r);
    return {clipped(l), clipped(r), sat16(l), sat16(r)};
  endfunction

  // Scoreboard: every sample strobe pops one expected entry per instance.
  always @(negedge clk) begin
    if (rst) begin
      if (sample0) begin
        total_cnt++;
        if (exp_q0.size() == 0) begin
          $display("FAIL mono_sample unexpected strobe got snd_l=%0d with no expected entry", snd_l0);
        end else begin
          e0 = exp_q0.pop_front();
          if ({clip_l0, clip_r0, snd_l0, snd_r0} !== e0)
            $display("FAIL mono_sample got clip=%b%b l=%0d r=%0d expected clip=%b%b l=%0d r=%0d",
                     clip_l0, clip_r0, snd_l0, snd_r0, e0[W-1], e0[W-2],
                     $signed(e0[2*OUTW-1:OUTW]), $signed(e0[OUTW-1:0]));
          else pass_cnt++;
        end
      end
      if (sample1) begin
        total_cnt++;
        if (exp_q1.size() == 0) begin
          $display("FAIL stereo_sample unexpected strobe got snd_l=%0d with no expected entry", snd_l1);
        end else begin
          e1 = exp_q1.pop_front();
          if ({clip_l1, clip_r1, snd_l1, snd_r1} !== e1)
            $display("FAIL stereo_sample got clip=%b%b l=%0d r=%0d expected clip=%b%b l=%0d r=%0d",
                     clip_l1, clip_r1, snd_l1, snd_r1, e1[W-1], e1[W-2],
                     $signed(e1[2*OUTW-1:OUTW]), $signed(e1[OUTW-1:0]));
          else pass_cnt++;
        end
      end
    end
  end

  // Driver: one cenop slot, model update, optional idle cycles with junk inputs.
  task automatic drive_slot(input int v, input bit z, input bit o, input bit c,
                            input bit rh, input bit pl, input bit pr);
    int cv, l, r;
    cv = (o || c) ? (rh ? 2 * v : v) : 0;
    l  = pl ? cv : 0;
    r  = pr ? cv : 0;
    if (z) begin
      if (first_f) begin
        exp_q0.push_back(pack(0, 0));
        exp_q1.push_back(pack(0, 0));
      end else begin
        exp_q0.push_back(pack(ml, ml));
        exp_q1.push_back(pack(ml, mr));
      end
      ml = l;
      mr = r;
      first_f = 1'b0;
    end else begin
      ml += l;
      mr += r;
    end
    cenop = 1'b1; op_result = v[12:0]; zero = z; op = o; con = c;
    rhy_IV = rh; pan_l = pl; pan_r = pr;
    @(posedge clk); #1;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        cenop = 1'b0; op_result = 13'($urandom); zero = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1)); con = 1'($urandom_range(0, 1));
        rhy_IV = 1'($urandom_range(0, 1)); pan_l = 1'b1; pan_r = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    cenop = 1'b0; zero = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full 18-slot frame; slots [a, a+n) carry v with the given flags, others are silent.
  task automatic frame(input int v, input int a, input int n, input bit o, input bit c,
                       input bit rh, input bit pl, input bit pr);
    for (int i = 0; i < 18; i++) begin
      if (i >= a && i < a + n) drive_slot(v, i == 0, o, c, rh, pl, pr);
      else drive_slot(0, i == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic apply_reset();
    idle(3);
    rst = 1'b0;
    #3;
    ml = 0; mr = 0; first_f = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({snd_l0, snd_r0, sample0, clip_l0, clip_r0, frame_err0} !== '0)
      $display("FAIL reset_mono got l=%0d r=%0d s=%b cl=%b cr=%b fe=%b expected all 0",
               snd_l0, snd_r0, sample0, clip_l0, clip_r0, frame_err0);
    else pass_cnt++;
    total_cnt++;
    if ({snd_l1, snd_r1, sample1, clip_l1, clip_r1, frame_err1} !== '0)
      $display("FAIL reset_stereo got l=%0d r=%0d s=%b fe=%b expected all 0",
               snd_l1, snd_r1, sample1, frame_err1);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single_carrier();
    frame(1000, 5, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l0 !== 16'sd1000 || snd_r0 !== 16'sd1000 || clip_l0 !== 1'b0)
      $display("FAIL single_carrier got l=%0d r=%0d clip=%b expected 1000 1000 0", snd_l0, snd_r0, clip_l0);
    else pass_cnt++;
  endtask

  task automatic test_rhythm();
    frame(4095, 3, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l0 !== 16'sd16380 || snd_r0 !== 16'sd16380)
      $display("FAIL rhythm got l=%0d r=%0d expected 16380 16380", snd_l0, snd_r0);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    frame(4095, 0, 18, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    frame(-4096, 0, 18, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l0 !== 16'sd32767 || clip_l0 !== 1'b1 || clip_r0 !== 1'b1)
      $display("FAIL sat_pos got l=%0d clip_l=%b clip_r=%b expected 32767 1 1", snd_l0, clip_l0, clip_r0);
    else pass_cnt++;
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l0 !== -16'sd32768 || clip_l0 !== 1'b1)
      $display("FAIL sat_neg got l=%0d clip_l=%b expected -32768 1", snd_l0, clip_l0);
    else pass_cnt++;
  endtask

  task automatic test_stereo();
    frame(-500, 7, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l1 !== -16'sd500 || snd_r1 !== 16'sd0)
      $display("FAIL stereo_pan got l=%0d r=%0d expected -500 0", snd_l1, snd_r1);
    else pass_cnt++;
    total_cnt++;
    if (snd_r0 !== -16'sd500)
      $display("FAIL mono_mirror got r=%0d expected -500", snd_r0);
    else pass_cnt++;
  endtask

  task automatic test_modulator();
    frame(4095, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (snd_l0 !== 16'sd0 || snd_r0 !== 16'sd0)
      $display("FAIL modulator got l=%0d r=%0d expected 0 0", snd_l0, snd_r0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 18; i++) begin
        drive_slot($urandom_range(0, 600) - 300, i == 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_back_to_back();
    gap_en = 1'b0;
    frame(123, 0, 18, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(-77, 4, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    gap_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    frame(300, 0, 18, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) drive_slot(200, i == 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    total_cnt++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0)
      $display("FAIL pending_samples got %0d/%0d queued expected 0", exp_q0.size(), exp_q1.size());
    else pass_cnt++;
    apply_reset();
    total_cnt++;
    if (snd_l0 !== 16'sd0 || sample0 !== 1'b0)
      $display("FAIL midframe_reset got l=%0d s=%b expected 0 0", snd_l0, sample0);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) drive_slot(50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(700, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_framing();
    apply_reset();
    for (int i = 0; i < 5; i++) drive_slot(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_err0 !== 1'b0) $display("FAIL first_zero_exempt got %b expected 0", frame_err0);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) drive_slot(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_err0 !== 1'b1) $display("FAIL short_frame got %b expected 1", frame_err0);
    else pass_cnt++;
    frame(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_err0 !== 1'b1) $display("FAIL err_sticky got %b expected 1", frame_err0);
    else pass_cnt++;
    idle(3);
    apply_reset();
    total_cnt++;
    if (frame_err0 !== 1'b0) $display("FAIL err_reset got %b expected 0", frame_err0);
    else pass_cnt++;
    for (int i = 0; i < 18; i++) drive_slot(0, i == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_err0 !== 1'b0) $display("FAIL full_frame_ok got %b expected 0", frame_err0);
    else pass_cnt++;
    drive_slot(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_err0 !== 1'b1) $display("FAIL long_frame got %b expected 1", frame_err0);
    else pass_cnt++;
    idle(3);
    apply_reset();
    total_cnt++;
    if (frame_err0 !== 1'b0) $display("FAIL err_reset2 got %b expected 0", frame_err0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_single_carrier();
    test_rhythm();
    test_saturation();
    test_stereo();
    test_modulator();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_framing();
    idle(4);
    total_cnt++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0)
      $display("FAIL drain got %0d/%0d unmatched expected 0", exp_q0.size(), exp_q1.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
